// File: rtl/spi_serdes_if.sv
// Bundle of the SPI pins and the clk-domain word handshake for spi_serdes.
// The master modport is the environment side and the slave modport is the serdes side.
interface spi_serdes_if #(
  parameter int PACKET_WIDTH = 8
) ();
  logic                    spi_SCLK;
  logic                    spi_SSEL;
  logic                    spi_MOSI;
  logic                    spi_MISO;
  logic [PACKET_WIDTH-1:0] txData;
  logic                    load;
  logic [PACKET_WIDTH-1:0] rxShiftReg;
  logic                    dataReady;

  modport master (
    output spi_SCLK, spi_SSEL, spi_MOSI, txData, load,
    input  spi_MISO, rxShiftReg, dataReady
  );

  modport slave (
    input  spi_SCLK, spi_SSEL, spi_MOSI, txData, load,
    output spi_MISO, rxShiftReg, dataReady
  );
endinterface

// File: rtl/spi_serdes.sv
// SPI mode-0 slave serdes, MSB first, oversampling the SPI pins in the clk domain.
// Receives words into rxShiftReg with a one-cycle dataReady strobe and shifts txData out on MISO.
module spi_serdes #(
  parameter int PACKET_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  spi_serdes_if.slave  bus
);
  localparam int CW = (PACKET_WIDTH > 2) ? $clog2(PACKET_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(PACKET_WIDTH - 1);

  logic                    r_sclk_meta;
  logic                    r_sclk_sync;
  logic                    r_sclk_prev;
  logic                    r_ssel_meta;
  logic                    r_ssel_sync;
  logic                    r_mosi_meta;
  logic                    r_mosi_sync;
  logic [PACKET_WIDTH-1:0] r_tx;
  logic [PACKET_WIDTH-1:0] r_rx;
  logic [CW-1:0]           r_cnt;
  logic                    r_ready;

  logic w_active;
  logic w_rise;
  logic w_fall;
  logic w_last;

  // Pin synchronizers plus the extra SCLK stage used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_ssel_meta <= 1'b1;
      r_ssel_sync <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sclk_meta <= bus.spi_SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_ssel_meta <= bus.spi_SSEL;
      r_ssel_sync <= r_ssel_meta;
      r_mosi_meta <= bus.spi_MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Edge events are gated by slave select so an idle bus never moves any state.
  always_comb begin
    w_active = ~r_ssel_sync;
    w_rise   = w_active & r_sclk_sync & ~r_sclk_prev;
    w_fall   = w_active & ~r_sclk_sync & r_sclk_prev;
    w_last   = (r_cnt == LAST_BIT);
  end

  // Transmit register: a load always beats a coincident shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx <= {PACKET_WIDTH{1'b0}};
    end else if (bus.load) begin
      r_tx <= bus.txData;
    end else if (w_fall) begin
      r_tx <= {r_tx[PACKET_WIDTH-2:0], 1'b0};
    end else begin
      r_tx <= r_tx;
    end
  end

  // Receive shifter, bit counter and the word-complete strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx    <= {PACKET_WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_ready <= 1'b0;
    end else if (!w_active) begin
      r_rx    <= r_rx;
      r_cnt   <= {CW{1'b0}};
      r_ready <= 1'b0;
    end else if (w_rise) begin
      r_rx    <= {r_rx[PACKET_WIDTH-2:0], r_mosi_sync};
      r_cnt   <= w_last ? {CW{1'b0}} : r_cnt + CW'(1);
      r_ready <= w_last;
    end else begin
      r_rx    <= r_rx;
      r_cnt   <= r_cnt;
      r_ready <= 1'b0;
    end
  end

  assign bus.spi_MISO   = r_tx[PACKET_WIDTH-1];
  assign bus.rxShiftReg = r_rx;
  assign bus.dataReady  = r_ready;
endmodule

// File: tb/tb_spi_serdes.sv
// Self-checking bench for spi_serdes: a bit-banged SPI master feeds a scoreboard
// queue of expected received words that an independent monitor consumes on dataReady.
module tb_spi_serdes;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   last_rise = 0;
  logic [W-1:0] sb_q[$];

  spi_serdes_if #(.PACKET_WIDTH(W)) bus ();

  spi_serdes #(.PACKET_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dataReady pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    int lat;
    if (rst_n === 1'b1 && bus.dataReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse with rx=%0h expected none", bus.rxShiftReg);
      end else begin
        exp_w = sb_q.pop_front();
        chk("rx_word", 32'(bus.rxShiftReg), 32'(exp_w));
        lat = cycle - last_rise;
        checks++;
        if (lat < 3 || lat > 5) begin
          errors++;
          $display("FAIL ready_latency: got %0d cycles expected 3..5", lat);
        end
      end
    end
  end

  task automatic do_load(input logic [W-1:0] d);
    bus.txData = d;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    chk("miso_after_load", 32'(bus.spi_MISO), 32'(d[W-1]));
  endtask

  task automatic send_bit(input logic b, input int half, output logic m);
    bus.spi_MOSI = b;
    repeat (half) @(negedge clk);
    chk("ready_idle", 32'(bus.dataReady), 32'd0);
    bus.spi_SCLK = 1'b1;
    last_rise    = cycle;
    m            = bus.spi_MISO;
    repeat (half) @(negedge clk);
    bus.spi_SCLK = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input int half,
                           input logic do_chk, input logic [W-1:0] exp_miso);
    logic [W-1:0] got;
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) sb_q.push_back(d);
      send_bit(d[i], half, got[i]);
    end
    if (do_chk) chk("miso_word", 32'(got), 32'(exp_miso));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic         m;
    logic [W-1:0] got;
    logic [W-1:0] word;
    logic [W-1:0] exp_tx;
    logic [W-1:0] collide;
    int           half;

    rst_n        = 1'b0;
    bus.spi_SCLK = 1'b0;
    bus.spi_SSEL = 1'b1;
    bus.spi_MOSI = 1'b0;
    bus.load     = 1'b0;
    bus.txData   = '0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(bus.spi_MISO), 32'd0);
    chk("reset_ready", 32'(bus.dataReady), 32'd0);
    chk("reset_rx", 32'(bus.rxShiftReg), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two back-to-back words with a 10-clk SCLK period.
    do_load(8'hff);
    bus.spi_SSEL = 1'b0;
    repeat (4) @(negedge clk);
    send_word(8'hab, 5, 1'b1, 8'hff);
    do_load(8'ha5);
    send_word(8'h15, 5, 1'b1, 8'ha5);

    // Partial word aborted by SSEL, then a clean word.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 5, m);
    bus.spi_SSEL = 1'b1;
    repeat (10) @(negedge clk);
    bus.spi_SSEL = 1'b0;
    repeat (4) @(negedge clk);
    do_load(8'hc3);
    send_word(8'h3c, 5, 1'b1, 8'hc3);

    // Reset in the middle of a word.
    do_load(8'h77);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 5, m);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_miso", 32'(bus.spi_MISO), 32'd0);
    chk("midreset_ready", 32'(bus.dataReady), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_load(8'h42);
    send_word(8'h81, 5, 1'b1, 8'h42);

    // Load coinciding with the falling-edge event after the first bit.
    do_load(8'hff);
    collide = 8'h5a;
    word    = 8'hc6;
    send_bit(word[W-1], 5, got[W-1]);
    chk("collide_first_bit", 32'(got[W-1]), 32'd1);
    repeat (2) @(negedge clk);
    bus.txData = collide;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    chk("miso_collision", 32'(bus.spi_MISO), 32'(collide[W-1]));
    for (int i = W - 2; i >= 0; i--) begin
      if (i == 0) sb_q.push_back(word);
      send_bit(word[i], 5, got[i]);
    end
    chk("collide_miso_bits", 32'(got[W-2:0]), 32'(collide[W-1:1]));
    repeat (4) @(negedge clk);

    // Random back-to-back traffic; a word sent without a fresh load shifts out zeros.
    for (int n = 0; n < 20; n++) begin
      half = $urandom_range(5, 7);
      word = W'($urandom);
      if (n == 0 || $urandom_range(0, 1) == 1) begin
        exp_tx = W'($urandom);
        do_load(exp_tx);
      end else begin
        exp_tx = '0;
      end
      send_word(word, half, 1'b1, exp_tx);
    end

    bus.spi_SSEL = 1'b1;
    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
